// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX controller: FSM state encoding and ARP opcodes.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARP_START = 3'd1,
    ARP_BUSY  = 3'd2,
    UDP_START = 3'd3,
    UDP_BUSY  = 3'd4,
    IFG       = 3'd5
  } state_t;

  localparam logic ARP_OP_REPLY = 1'b0;
  localparam logic ARP_OP_REQ   = 1'b1;

  // One counter covers start timeout, frame length and IFG; frame length needs 11 bits.
  localparam int CNT_W = 11;

endpackage

// File: rtl/eth_tx_ctrl_if.sv
// Bundle of ARP, UDP, RGMII-side and cache signals around the TX controller.
// master = controller view, slave = surrounding blocks / environment view.
interface eth_tx_ctrl_if;
  logic        arp_req_trig;
  logic        arp_rx_done;
  logic        arp_rx_op;
  logic [47:0] pc_mac;
  logic [31:0] pc_ip;
  logic        arp_tx_en;
  logic        arp_tx_op;
  logic [7:0]  arp_tx_data;
  logic        arp_tx_valid;
  logic        udp_tx_req;
  logic        udp_tx_grant;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_valid;
  logic [7:0]  eth_tx_data;
  logic        eth_tx_valid;
  logic [47:0] peer_mac;
  logic [31:0] peer_ip;
  logic        peer_valid;
  logic        timeout_err;

  modport master (
    input  arp_req_trig, arp_rx_done, arp_rx_op, pc_mac, pc_ip,
    input  arp_tx_data, arp_tx_valid,
    input  udp_tx_req, udp_tx_data, udp_tx_valid,
    output arp_tx_en, arp_tx_op, udp_tx_grant,
    output eth_tx_data, eth_tx_valid,
    output peer_mac, peer_ip, peer_valid, timeout_err
  );

  modport slave (
    output arp_req_trig, arp_rx_done, arp_rx_op, pc_mac, pc_ip,
    output arp_tx_data, arp_tx_valid,
    output udp_tx_req, udp_tx_data, udp_tx_valid,
    input  arp_tx_en, arp_tx_op, udp_tx_grant,
    input  eth_tx_data, eth_tx_valid,
    input  peer_mac, peer_ip, peer_valid, timeout_err
  );
endinterface

// File: rtl/eth_tx_mux.sv
// Registered 2:1 byte mux feeding RGMII TX; one cycle latency, force_idle wins over owner.
module eth_tx_mux (
  input  logic       clk,
  input  logic       rstn,
  input  logic       owner_udp,
  input  logic       force_idle,
  input  logic [7:0] arp_data,
  input  logic       arp_valid,
  input  logic [7:0] udp_data,
  input  logic       udp_valid,
  output logic [7:0] data,
  output logic       valid
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data  <= 8'h00;
      valid <= 1'b0;
    end else if (force_idle) begin
      data  <= 8'h00;
      valid <= 1'b0;
    end else if (owner_udp) begin
      data  <= udp_data;
      valid <= udp_valid;
    end else begin
      data  <= arp_data;
      valid <= arp_valid;
    end
  end

endmodule

// File: rtl/eth_tx_ctrl.sv
// ARP reply/request sequencer, peer cache and ARP/UDP arbiter for the GMII TX byte stream.
// ARP start strobe two cycles after a request arrives; data path adds one register stage.
module eth_tx_ctrl
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 16,
  parameter int FRAME_TIMEOUT = 2047
) (
  input  logic          clk,
  input  logic          rstn,
  eth_tx_ctrl_if.master bus
);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             reply_pend, req_pend;
  logic             start_arp, abort, op_sel;
  logic             arp_tx_en_q, arp_tx_op_q, timeout_q;
  logic [47:0]      peer_mac_q;
  logic [31:0]      peer_ip_q;
  logic             peer_valid_q;
  logic             owner_udp, owner_arp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_W'(1);
    start_arp = 1'b0;
    abort     = 1'b0;
    op_sel    = arp_tx_op_q;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (reply_pend) begin
          start_arp = 1'b1;
          op_sel    = ARP_OP_REPLY;
          state_d   = ARP_START;
        end else if (req_pend) begin
          start_arp = 1'b1;
          op_sel    = ARP_OP_REQ;
          state_d   = ARP_START;
        end else if (bus.udp_tx_req && peer_valid_q) begin
          state_d = UDP_START;
        end
      end
      ARP_START: begin
        if (bus.arp_tx_valid) begin
          state_d = ARP_BUSY;
          cnt_d   = CNT_W'(1);
        end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IFG;
          cnt_d   = '0;
        end
      end
      ARP_BUSY: begin
        if (!bus.arp_tx_valid) begin
          state_d = IFG;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(FRAME_TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IFG;
          cnt_d   = '0;
        end
      end
      UDP_START: begin
        if (bus.udp_tx_valid) begin
          state_d = UDP_BUSY;
          cnt_d   = CNT_W'(1);
        end else if (!bus.udp_tx_req) begin
          state_d = IFG;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IFG;
          cnt_d   = '0;
        end
      end
      UDP_BUSY: begin
        if (!bus.udp_tx_valid) begin
          state_d = IFG;
          cnt_d   = '0;
        end else if (cnt == CNT_W'(FRAME_TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IFG;
          cnt_d   = '0;
        end
      end
      IFG: begin
        if (cnt == CNT_W'(IFG_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A new event in the same cycle as the strobe keeps its flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reply_pend <= 1'b0;
      req_pend   <= 1'b0;
    end else begin
      if (bus.arp_rx_done && bus.arp_rx_op)
        reply_pend <= 1'b1;
      else if (start_arp && op_sel == ARP_OP_REPLY)
        reply_pend <= 1'b0;
      if (bus.arp_req_trig)
        req_pend <= 1'b1;
      else if (start_arp && op_sel == ARP_OP_REQ)
        req_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arp_tx_en_q  <= 1'b0;
      arp_tx_op_q  <= 1'b0;
      timeout_q    <= 1'b0;
      peer_mac_q   <= '0;
      peer_ip_q    <= '0;
      peer_valid_q <= 1'b0;
    end else begin
      arp_tx_en_q <= start_arp;
      timeout_q   <= abort;
      if (start_arp)
        arp_tx_op_q <= op_sel;
      if (bus.arp_rx_done) begin
        peer_mac_q   <= bus.pc_mac;
        peer_ip_q    <= bus.pc_ip;
        peer_valid_q <= 1'b1;
      end
    end
  end

  assign owner_udp = (state == UDP_START) || (state == UDP_BUSY);
  assign owner_arp = (state == ARP_START) || (state == ARP_BUSY);

  eth_tx_mux u_mux (
    .clk        (clk),
    .rstn       (rstn),
    .owner_udp  (owner_udp),
    .force_idle (!(owner_udp || owner_arp)),
    .arp_data   (bus.arp_tx_data),
    .arp_valid  (bus.arp_tx_valid),
    .udp_data   (bus.udp_tx_data),
    .udp_valid  (bus.udp_tx_valid),
    .data       (bus.eth_tx_data),
    .valid      (bus.eth_tx_valid)
  );

  assign bus.arp_tx_en    = arp_tx_en_q;
  assign bus.arp_tx_op    = arp_tx_op_q;
  assign bus.udp_tx_grant = owner_udp;
  assign bus.timeout_err  = timeout_q;
  assign bus.peer_mac     = peer_mac_q;
  assign bus.peer_ip      = peer_ip_q;
  assign bus.peer_valid   = peer_valid_q;

endmodule

// File: tb/tb_eth_tx_ctrl.sv
// Directed bench for eth_tx_ctrl: ARP reply/request sequencing, arbitration, timeouts, reset.
module tb_eth_tx_ctrl;
  import eth_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  eth_tx_ctrl_if bus();

  eth_tx_ctrl #(
    .IFG_CYCLES    (12),
    .START_TIMEOUT (16),
    .FRAME_TIMEOUT (2047)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int good, bad, cnt_v;
  logic found;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.arp_req_trig = 1'b0;
    bus.arp_rx_done  = 1'b0;
    bus.arp_rx_op    = 1'b0;
    bus.pc_mac       = '0;
    bus.pc_ip        = '0;
    bus.arp_tx_data  = '0;
    bus.arp_tx_valid = 1'b0;
    bus.udp_tx_req   = 1'b0;
    bus.udp_tx_data  = '0;
    bus.udp_tx_valid = 1'b0;
    tick();
    tick();
    chk_b("rst_eth_valid", bus.eth_tx_valid, 1'b0);
    chk_b("rst_arp_en", bus.arp_tx_en, 1'b0);
    chk_b("rst_arp_op", bus.arp_tx_op, 1'b0);
    chk_b("rst_grant", bus.udp_tx_grant, 1'b0);
    chk_b("rst_peer_valid", bus.peer_valid, 1'b0);
    chk_b("rst_timeout", bus.timeout_err, 1'b0);
    chk_v("rst_peer_mac", 64'(bus.peer_mac), 64'h0);
    rstn = 1'b1;
    tick();

    // ARP reply path
    bus.arp_rx_done = 1'b1;
    bus.arp_rx_op   = 1'b1;
    bus.pc_mac      = 48'h001122334455;
    bus.pc_ip       = 32'hC0A80102;
    tick();
    bus.arp_rx_done = 1'b0;
    bus.arp_rx_op   = 1'b0;
    chk_v("peer_mac", 64'(bus.peer_mac), 64'h001122334455);
    chk_v("peer_ip", 64'(bus.peer_ip), 64'hC0A80102);
    chk_b("peer_valid", bus.peer_valid, 1'b1);
    chk_b("reply_en_early", bus.arp_tx_en, 1'b0);
    tick();
    chk_b("reply_en", bus.arp_tx_en, 1'b1);
    chk_b("reply_op", bus.arp_tx_op, ARP_OP_REPLY);
    tick();
    chk_b("reply_en_pulse", bus.arp_tx_en, 1'b0);
    good = 0;
    for (int i = 0; i < 60; i++) begin
      bus.arp_tx_data  = 8'(i + 1);
      bus.arp_tx_valid = 1'b1;
      tick();
      if (bus.eth_tx_valid === 1'b1 && bus.eth_tx_data === 8'(i + 1)) good++;
    end
    bus.arp_tx_valid = 1'b0;
    bus.arp_tx_data  = '0;
    tick();
    chk_v("arp_frame_bytes", 64'(good), 64'd60);
    chk_b("arp_frame_end", bus.eth_tx_valid, 1'b0);

    // IFG of 12 cycles, then UDP is granted (cache now valid)
    bus.udp_tx_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.eth_tx_valid !== 1'b0 || bus.udp_tx_grant !== 1'b0 || bus.arp_tx_en !== 1'b0) bad++;
    end
    chk_v("ifg_quiet", 64'(bad), 64'd0);
    tick();
    chk_b("udp_grant_after_ifg", bus.udp_tx_grant, 1'b1);

    // 100-byte UDP frame with two ARP requests and one trigger arriving mid-frame
    good = 0;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      bus.udp_tx_data  = 8'(i * 3);
      bus.udp_tx_valid = 1'b1;
      bus.arp_rx_done  = (i == 10) || (i == 20);
      bus.arp_rx_op    = 1'b1;
      bus.pc_mac       = 48'hA1A2A3A4A5A6;
      bus.pc_ip        = 32'h0A000001;
      bus.arp_req_trig = (i == 30);
      bus.arp_tx_valid = (i >= 50) && (i < 56);
      bus.arp_tx_data  = 8'hEE;
      tick();
      if (bus.eth_tx_valid === 1'b1 && bus.eth_tx_data === 8'(i * 3)) good++;
      if (bus.arp_tx_en !== 1'b0) bad++;
    end
    bus.udp_tx_valid = 1'b0;
    bus.arp_rx_done  = 1'b0;
    bus.arp_rx_op    = 1'b0;
    bus.arp_req_trig = 1'b0;
    bus.arp_tx_valid = 1'b0;
    tick();
    chk_v("udp_frame_bytes", 64'(good), 64'd100);
    chk_v("no_arp_during_udp", 64'(bad), 64'd0);
    chk_b("udp_frame_end", bus.eth_tx_valid, 1'b0);
    chk_b("grant_drop", bus.udp_tx_grant, 1'b0);
    chk_v("peer_mac_update", 64'(bus.peer_mac), 64'hA1A2A3A4A5A6);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.arp_tx_en !== 1'b0) bad++;
    end
    chk_v("reply_wait_ifg", 64'(bad), 64'd0);
    tick();
    chk_b("coal_reply_en", bus.arp_tx_en, 1'b1);
    chk_b("coal_reply_op", bus.arp_tx_op, ARP_OP_REPLY);
    bus.arp_tx_valid = 1'b1;
    bus.arp_tx_data  = 8'h55;
    tick();
    chk_b("coal_reply_pulse", bus.arp_tx_en, 1'b0);
    tick();
    chk_b("short_arp_valid", bus.eth_tx_valid, 1'b1);
    chk_v("short_arp_data", 64'(bus.eth_tx_data), 64'h55);
    bus.arp_tx_valid = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.arp_tx_en !== 1'b0) bad++;
    end
    chk_v("req_wait_ifg", 64'(bad), 64'd0);
    tick();
    chk_b("coal_req_en", bus.arp_tx_en, 1'b1);
    chk_b("coal_req_op", bus.arp_tx_op, ARP_OP_REQ);
    bus.arp_tx_valid = 1'b1;
    tick();
    bus.arp_tx_valid = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.arp_tx_en !== 1'b0 || bus.udp_tx_grant !== 1'b0) bad++;
    end
    chk_v("single_reply_single_req", 64'(bad), 64'd0);
    tick();
    chk_b("grant_after_arp", bus.udp_tx_grant, 1'b1);
    chk_b("no_third_arp", bus.arp_tx_en, 1'b0);
    bus.udp_tx_req = 1'b0;
    tick();
    chk_b("req_drop_grant", bus.udp_tx_grant, 1'b0);
    chk_b("req_drop_no_err", bus.timeout_err, 1'b0);

    // Start timeout: strobe issued, arp_tx_valid never rises
    bus.arp_req_trig = 1'b1;
    tick();
    bus.arp_req_trig = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 30 && !found; j++) begin
      tick();
      found = bus.arp_tx_en;
    end
    chk_b("st_to_en_seen", found, 1'b1);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.timeout_err !== 1'b0 || bus.eth_tx_valid !== 1'b0) bad++;
    end
    chk_v("st_to_quiet", 64'(bad), 64'd0);
    tick();
    chk_b("st_to_err", bus.timeout_err, 1'b1);
    chk_b("st_to_eth_valid", bus.eth_tx_valid, 1'b0);
    tick();
    chk_b("st_to_err_pulse", bus.timeout_err, 1'b0);

    // Frame timeout: UDP valid stuck high
    bus.udp_tx_req   = 1'b1;
    bus.udp_tx_valid = 1'b1;
    bus.udp_tx_data  = 8'h77;
    found = 1'b0;
    for (int j = 0; j < 30 && !found; j++) begin
      tick();
      found = bus.udp_tx_grant;
    end
    chk_b("fr_to_grant_seen", found, 1'b1);
    cnt_v = 0;
    found = 1'b0;
    for (int j = 0; j < 2100 && !found; j++) begin
      tick();
      if (bus.eth_tx_valid === 1'b1) cnt_v++;
      found = bus.timeout_err;
    end
    chk_b("fr_to_err_seen", found, 1'b1);
    chk_v("fr_to_valid_cycles", 64'(cnt_v), 64'd2047);
    chk_b("fr_to_grant_drop", bus.udp_tx_grant, 1'b0);
    bus.udp_tx_valid = 1'b0;
    bus.udp_tx_req   = 1'b0;
    tick();
    chk_b("fr_to_eth_low", bus.eth_tx_valid, 1'b0);
    chk_b("fr_to_err_pulse", bus.timeout_err, 1'b0);

    // Async reset in the middle of an ARP frame with a request pending
    bus.arp_req_trig = 1'b1;
    tick();
    bus.arp_req_trig = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 30 && !found; j++) begin
      tick();
      found = bus.arp_tx_en;
    end
    chk_b("rst_mid_en_seen", found, 1'b1);
    bus.arp_tx_valid = 1'b1;
    bus.arp_tx_data  = 8'h3C;
    tick();
    tick();
    chk_b("rst_mid_busy", bus.eth_tx_valid, 1'b1);
    bus.arp_req_trig = 1'b1;
    tick();
    bus.arp_req_trig = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk_b("rst_async_eth_valid", bus.eth_tx_valid, 1'b0);
    chk_b("rst_async_peer_valid", bus.peer_valid, 1'b0);
    chk_v("rst_async_peer_ip", 64'(bus.peer_ip), 64'h0);
    bus.arp_tx_valid = 1'b0;
    tick();
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.arp_tx_en !== 1'b0 || bus.eth_tx_valid !== 1'b0) bad++;
    end
    chk_v("rst_pending_lost", 64'(bad), 64'd0);

    // UDP gated until the cache holds a peer
    bus.udp_tx_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.udp_tx_grant !== 1'b0) bad++;
    end
    chk_v("gate_no_grant", 64'(bad), 64'd0);
    bus.arp_rx_done = 1'b1;
    bus.arp_rx_op   = 1'b0;
    bus.pc_mac      = 48'h0A0B0C0D0E0F;
    bus.pc_ip       = 32'hC0A80105;
    tick();
    bus.arp_rx_done = 1'b0;
    chk_b("gate_peer_valid", bus.peer_valid, 1'b1);
    chk_b("gate_grant_early", bus.udp_tx_grant, 1'b0);
    tick();
    chk_b("gate_grant", bus.udp_tx_grant, 1'b1);
    chk_b("gate_no_reply", bus.arp_tx_en, 1'b0);
    bus.udp_tx_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
